// File: rtl/nanci_row_loader_pkg.sv
// Shared definitions for the Nanci row loader: FSM state encodings and
// helpers for sizing the packed PE words and the phase counter.
package nanci_row_loader_pkg;

  // Loader FSM encodings, 3 bits, shared with the mesh top and other loaders
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Width of one packed {addr,data} PE word
  function automatic int word_width(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Phase counter must hold the larger of the two phase lengths
  function automatic int cnt_width(input int hold_cycles, input int run_cycles);
    return $clog2(max_int(hold_cycles, run_cycles) + 1);
  endfunction

endpackage

// File: rtl/nanci_row_loader_cycle_counter.sv
// Load/enable down-counter with terminal-count flag. Used to time the
// HOLD and RUN phases of the row loader; a phase of L cycles is obtained
// by loading L-1 and leaving the phase when tc is seen.
module nanci_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Count down while enabled; park at zero rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/nanci_row_loader.sv
// Row loader for the Nanci sort mesh. Streams N keys in, tags each with
// its arrival index, presents them as packed {addr,data} words on the
// row's left-edge inputs, then sequences the row's PE reset:
// held through load and a settle window, released for a fixed sort
// window, then done is flagged with the PEs left out of reset.
module nanci_row_loader
  import nanci_row_loader_pkg::*;
#(
  parameter int N           = 4,
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int RUN_CYCLES  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_start,
  input  logic                                     i_valid,
  input  logic [DATA_WIDTH-1:0]                    i_data,
  output logic                                     o_ready,
  output logic [N*(ADDR_WIDTH+DATA_WIDTH)-1:0]     o_PE_l,
  output logic                                     o_rst_pe,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int W  = word_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = cnt_width(HOLD_CYCLES, RUN_CYCLES);

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [ADDR_WIDTH-1:0] idx;
  logic [N*W-1:0]        pe_l;
  logic                  start_take;
  logic                  accept;
  logic                  last_key;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_value;
  logic                  cnt_en;
  logic                  cnt_tc;

  // i_start only counts when the loader is parked; keys only while filling
  assign start_take = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept     = i_valid && (state == ST_FILL);
  assign last_key   = accept && (idx == ADDR_WIDTH'(N - 1));
  assign cnt_en     = (state == ST_HOLD) || (state == ST_RUN);

  nanci_cycle_counter #(
    .WIDTH (CW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (cnt_en),
    .tc         (cnt_tc)
  );

  // Next-state and phase-counter load decode
  always_comb begin
    state_nx  = state;
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) state_nx = ST_FILL;
      end
      ST_FILL: begin
        if (last_key) begin
          state_nx  = ST_HOLD;
          cnt_load  = 1'b1;
          cnt_value = CW'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_tc) begin
          state_nx  = ST_RUN;
          cnt_load  = 1'b1;
          cnt_value = CW'(RUN_CYCLES - 1);
        end
      end
      ST_RUN: begin
        if (cnt_tc) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Slice array and arrival index; a new load wipes the previous row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      pe_l <= '0;
    end else if (start_take) begin
      idx  <= '0;
      pe_l <= '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (idx == ADDR_WIDTH'(k)) pe_l[k*W +: W] <= {idx, i_data};
      end
      idx <= idx + ADDR_WIDTH'(1);
    end
  end

  // PE reset is held everywhere except the sort window and DONE, so the
  // PEs keep their sorted results until the next load starts
  assign o_ready  = (state == ST_FILL);
  assign o_rst_pe = (state != ST_RUN) && (state != ST_DONE);
  assign o_busy   = (state == ST_FILL) || (state == ST_HOLD) || (state == ST_RUN);
  assign o_done   = (state == ST_DONE);
  assign o_PE_l   = pe_l;

endmodule

// File: tb/tb_nanci_row_loader.sv
// Directed bench for nanci_row_loader: a 4-PE row and a 1-PE row with a
// small behavioural PE that captures its left input once out of reset.
module tb_nanci_row_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, valid;
  logic [2:0]  data;
  logic        ready, rst_pe, busy, done;
  logic [23:0] pe_l;

  logic        start1, valid1;
  logic [2:0]  data1;
  logic        ready1, rst_pe1, busy1, done1;
  logic [5:0]  pe_l1;
  logic [5:0]  pe_q;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] EXP_A  = 24'b011001_010111_001010_000101;
  localparam logic [23:0] EXP_A2 = 24'b000000_000000_001010_000101;
  localparam logic [23:0] EXP_B  = 24'b011011_010011_001011_000011;

  always #5 clk = ~clk;

  nanci_row_loader #(.N(4), .ADDR_WIDTH(3), .DATA_WIDTH(3), .HOLD_CYCLES(2), .RUN_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_PE_l(pe_l), .o_rst_pe(rst_pe), .o_busy(busy), .o_done(done));

  nanci_row_loader #(.N(1), .ADDR_WIDTH(3), .DATA_WIDTH(3), .HOLD_CYCLES(2), .RUN_CYCLES(8)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_valid(valid1), .i_data(data1),
    .o_ready(ready1), .o_PE_l(pe_l1), .o_rst_pe(rst_pe1), .o_busy(busy1), .o_done(done1));

  // Behavioural PE: cleared while in reset, latches its left neighbour otherwise
  always @(posedge clk or posedge rst) begin
    if (rst)          pe_q <= '0;
    else if (rst_pe1) pe_q <= '0;
    else              pe_q <= pe_l1;
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_key(input logic [2:0] d);
    valid = 1'b1; data = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rst_pe !== 1'b1) begin errors++; $display("FAIL reset_rst_pe got %b exp 1", rst_pe); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (pe_l !== 24'h0) begin errors++; $display("FAIL reset_pe_l got %h exp 0", pe_l); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %b%b exp 00", done, busy); end
    rst = 1'b0;
    do_start();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_fill_entry ready got %b exp 1", ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || rst_pe !== 1'b1 || busy !== 1'b0 || pe_l !== 24'h0)
      begin errors++; $display("FAIL reset_async got rdy=%b rpe=%b busy=%b pe=%h exp 0 1 0 0", ready, rst_pe, busy, pe_l); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_start();
    checks++; if (pe_l !== 24'h0) begin errors++; $display("FAIL b2b_cleared got %h exp 0", pe_l); end
    send_key(3'd5); send_key(3'd2); send_key(3'd7); send_key(3'd1);
    checks++; if (pe_l !== EXP_A) begin errors++; $display("FAIL b2b_slices got %h exp %h", pe_l, EXP_A); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold got %b exp 0", ready); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rst_pe !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_hold%0d got rpe=%b busy=%b exp 1 1", i, rst_pe, busy); end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rst_pe !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_run%0d got rpe=%b done=%b exp 0 0", i, rst_pe, done); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || rst_pe !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_done got done=%b rpe=%b busy=%b exp 1 0 0", done, rst_pe, busy); end
  endtask

  task automatic test_gapped();
    logic [2:0] keys [4];
    int n;
    keys = '{3'd5, 3'd2, 3'd7, 3'd1};
    do_start();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = keys[i];
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL gap_ready_key%0d got %b exp 1", i, ready); end
      @(negedge clk);
      valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          checks++; if (ready !== 1'b1) begin errors++; $display("FAIL gap_ready_idle%0d_%0d got %b exp 1", i, g, ready); end
          @(negedge clk);
        end
      end
    end
    valid = 1'b1; data = 3'd4;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL gap_fifth_ready got %b exp 0", ready); end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (pe_l !== EXP_A) begin errors++; $display("FAIL gap_slices got %h exp %h", pe_l, EXP_A); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done_timeout got %b exp 1", done); end
  endtask

  task automatic test_start_ignored();
    int n;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_pre_done got %b exp 1", done); end
    do_start();
    checks++; if (done !== 1'b0 || rst_pe !== 1'b1 || pe_l !== 24'h0)
      begin errors++; $display("FAIL ign_restart got done=%b rpe=%b pe=%h exp 0 1 0", done, rst_pe, pe_l); end
    send_key(3'd5); send_key(3'd2);
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (ready !== 1'b1 || pe_l !== EXP_A2)
      begin errors++; $display("FAIL ign_fill got rdy=%b pe=%h exp 1 %h", ready, pe_l, EXP_A2); end
    send_key(3'd7); send_key(3'd1);
    checks++; if (pe_l !== EXP_A) begin errors++; $display("FAIL ign_slices got %h exp %h", pe_l, EXP_A); end
    n = 0;
    while (rst_pe !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1 || rst_pe !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL ign_run got busy=%b rpe=%b done=%b exp 1 0 0", busy, rst_pe, done); end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1 || pe_l !== EXP_A)
      begin errors++; $display("FAIL ign_done got done=%b pe=%h exp 1 %h", done, pe_l, EXP_A); end
  endtask

  task automatic test_reset_midfill();
    int n;
    do_start();
    send_key(3'd5); send_key(3'd2);
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || pe_l !== 24'h0 || rst_pe !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL mid_reset got rdy=%b pe=%h rpe=%b busy=%b done=%b exp 0 0 1 0 0", ready, pe_l, rst_pe, busy, done); end
    @(negedge clk); rst = 1'b0;
    do_start();
    send_key(3'd3); send_key(3'd3); send_key(3'd3); send_key(3'd3);
    checks++; if (pe_l !== EXP_B) begin errors++; $display("FAIL mid_reload got %h exp %h", pe_l, EXP_B); end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done_timeout got %b exp 1", done); end
  endtask

  task automatic test_single_pe();
    int n;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    valid1 = 1'b1; data1 = 3'd1;
    @(negedge clk); valid1 = 1'b0;
    checks++; if (ready1 !== 1'b0 || pe_l1 !== 6'b000_001 || busy1 !== 1'b1)
      begin errors++; $display("FAIL n1_slice got rdy=%b pe=%b busy=%b exp 0 000001 1", ready1, pe_l1, busy1); end
    n = 0;
    while (done1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (done1 !== 1'b1 || rst_pe1 !== 1'b0)
      begin errors++; $display("FAIL n1_done got done=%b rpe=%b exp 1 0", done1, rst_pe1); end
    checks++; if (pe_q !== 6'b000_001) begin errors++; $display("FAIL n1_pe_out got %b exp 000001", pe_q); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
    start1 = 1'b0; valid1 = 1'b0; data1 = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_start_ignored();
    test_reset_midfill();
    test_single_pe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
